alu_issue: RTL and testbench

- Issue-side driver for the core's combinational ALU. It accepts decoded integer instructions over a valid/ready handshake and generates the 4-bit ALU op code and both operands.
- It registers the operands into the ALU, captures the ALU result, and presents a writeback packet over a second valid/ready handshake.
- It is a two-stage pipeline (issue register, result register) between decode and the register-file writeback.
- Throughput is one instruction per cycle.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_issue_if.sv | 43 ++++
 rtl/alu_op_decode.sv | 61 ++++++
 rtl/alu_issue.sv | 100 ++++++++++
 tb/tb_alu_issue.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and helpers for the ALU issue block.
//   - ALU op codes driven on alu_op_o (bit 3 selects SUB/SRA flavour)
//   - major opcodes decoded by alu_op_decode
//   - shift-amount mask helper and the writeback packet struct
package alu_pkg;

  localparam int DW = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // Shift ops are x001 / x101 regardless of the SRA flavour bit.
  function automatic logic is_shift(input logic [3:0] op);
    return (op[2:0] == 3'b001) || (op[2:0] == 3'b101);
  endfunction

  // Shifts only ever see a 5-bit shift amount on operand B.
  function automatic logic [DW-1:0] shift_mask(input logic [3:0] op,
                                               input logic [DW-1:0] b);
    return is_shift(op) ? {27'b0, b[4:0]} : b;
  endfunction

  typedef struct packed {
    logic          illegal;
    logic          we;
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } wb_t;

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: all handshake and datapath signals of alu_issue.
//   master: the surrounding core (decode, ALU, writeback consumer)
//   slave : alu_issue itself
//   decode side  : flush_i, in_valid_i/in_ready_o, opcode/funct/operands/pc/rd
//   ALU side     : alu_in0_o, alu_in1_o, alu_op_o out; alu_out_i back
//   writeback    : wb_valid_o/wb_ready_i, wb_rd_o, wb_we_o, wb_data_o, wb_illegal_o
interface alu_issue_if #(parameter int XLEN = 32);
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [6:0]      opcode_i;
  logic [2:0]      funct3_i;
  logic            funct7b5_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] pc_i;
  logic [4:0]      rd_i;
  logic [XLEN-1:0] alu_in0_o;
  logic [XLEN-1:0] alu_in1_o;
  logic [3:0]      alu_op_o;
  logic [XLEN-1:0] alu_out_i;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic [4:0]      wb_rd_o;
  logic            wb_we_o;
  logic [XLEN-1:0] wb_data_o;
  logic            wb_illegal_o;

  modport master (
    output flush_i, in_valid_i, opcode_i, funct3_i, funct7b5_i,
           rs1_data_i, rs2_data_i, imm_i, pc_i, rd_i, alu_out_i, wb_ready_i,
    input  in_ready_o, alu_in0_o, alu_in1_o, alu_op_o,
           wb_valid_o, wb_rd_o, wb_we_o, wb_data_o, wb_illegal_o
  );

  modport slave (
    input  flush_i, in_valid_i, opcode_i, funct3_i, funct7b5_i,
           rs1_data_i, rs2_data_i, imm_i, pc_i, rd_i, alu_out_i, wb_ready_i,
    output in_ready_o, alu_in0_o, alu_in1_o, alu_op_o,
           wb_valid_o, wb_rd_o, wb_we_o, wb_data_o, wb_illegal_o
  );
endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational instruction -> ALU control decode.
//   in : opcode, funct3, funct7b5, rs1, rs2, imm, pc
//   out: op (4-bit ALU code), in0/in1 (operands), illegal
// Illegal encodings present ADD 0+0 so the ALU produces 0 on its own.
module alu_op_decode
  import alu_pkg::*;
#(parameter int XLEN = 32)
(
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [3:0]      op,
  output logic [XLEN-1:0] in0,
  output logic [XLEN-1:0] in1,
  output logic            illegal
);

  always_comb begin
    op      = ALU_ADD;
    in0     = '0;
    in1     = '0;
    illegal = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        op      = {funct7b5, funct3};
        in0     = rs1;
        in1     = rs2;
        // bit 30 is only meaningful for SUB and SRA
        illegal = funct7b5 && !(funct3 == 3'b000 || funct3 == 3'b101);
      end
      OPC_OPIMM: begin
        // no SUBI: bit 30 only distinguishes SRAI from SRLI
        op      = (funct3 == 3'b101) ? {funct7b5, funct3} : {1'b0, funct3};
        in0     = rs1;
        in1     = imm;
        illegal = (funct3 == 3'b001) && funct7b5;
      end
      OPC_LUI: begin
        in1 = imm;
      end
      OPC_AUIPC: begin
        in0 = pc;
        in1 = imm;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      op  = ALU_ADD;
      in0 = '0;
      in1 = '0;
    end else begin
      in1 = shift_mask(op, in1);
    end
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/result pipeline around an external ALU.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : decode handshake in, registered ALU operands/op out,
//                  ALU result in, writeback packet handshake out
// Stage 1 (issue register) drives the ALU; stage 2 captures its result.
// One instruction per cycle; a full pipeline drains and fills in one edge.
module alu_issue
  import alu_pkg::*;
#(parameter int XLEN = 32)  // only 32 supported
(
  input logic        clk_i,
  input logic        rst_i,
  alu_issue_if.slave bus
);

  // vld_pipe[1] = issue stage holds an instruction, vld_pipe[2] = wb valid
  logic [2:1]      vld_pipe;
  logic            s2_free, s1_adv, take;

  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_in0, dec_in1;
  logic            dec_ill;

  logic [3:0]      op_q;
  logic [XLEN-1:0] in0_q, in1_q;
  logic [4:0]      rd_q;
  logic            we_q, ill_q;
  wb_t             wb_q;

  alu_op_decode #(.XLEN(XLEN)) u_dec (
    .opcode  (bus.opcode_i),
    .funct3  (bus.funct3_i),
    .funct7b5(bus.funct7b5_i),
    .rs1     (bus.rs1_data_i),
    .rs2     (bus.rs2_data_i),
    .imm     (bus.imm_i),
    .pc      (bus.pc_i),
    .op      (dec_op),
    .in0     (dec_in0),
    .in1     (dec_in1),
    .illegal (dec_ill)
  );

  assign s2_free = !vld_pipe[2] | bus.wb_ready_i;
  assign s1_adv  = vld_pipe[1] & s2_free;
  // combinational from wb_ready_i; flush blocks any new acceptance
  assign bus.in_ready_o = !bus.flush_i & (!vld_pipe[1] | s2_free);
  assign take = bus.in_valid_i & bus.in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      op_q     <= ALU_ADD;
      in0_q    <= '0;
      in1_q    <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      ill_q    <= 1'b0;
      wb_q     <= '0;
    end else begin
      // issue stage; flush wins over everything, new take wins over drain
      if (bus.flush_i) begin
        vld_pipe[1] <= 1'b0;
      end else if (take) begin
        vld_pipe[1] <= 1'b1;
        op_q        <= dec_op;
        in0_q       <= dec_in0;
        in1_q       <= dec_in1;
        rd_q        <= bus.rd_i;
        we_q        <= !dec_ill && (bus.rd_i != 5'd0);
        ill_q       <= dec_ill;
      end else if (s1_adv) begin
        vld_pipe[1] <= 1'b0;
      end

      // result stage; payload only changes on load so a stall holds it
      if (bus.flush_i) begin
        vld_pipe[2] <= 1'b0;
      end else if (s1_adv) begin
        vld_pipe[2]  <= 1'b1;
        wb_q.illegal <= ill_q;
        wb_q.we      <= we_q;
        wb_q.rd      <= rd_q;
        wb_q.data    <= ill_q ? '0 : bus.alu_out_i;
      end else if (bus.wb_ready_i) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end

  assign bus.alu_op_o     = op_q;
  assign bus.alu_in0_o    = in0_q;
  assign bus.alu_in1_o    = in1_q;
  assign bus.wb_valid_o   = vld_pipe[2];
  assign bus.wb_rd_o      = wb_q.rd;
  assign bus.wb_we_o      = wb_q.we;
  assign bus.wb_data_o    = wb_q.data;
  assign bus.wb_illegal_o = wb_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed plus randomized bench for alu_issue.
// A behavioural ALU answers alu_out_i; a scoreboard predicts every
// writeback packet from instruction semantics.
module tb_alu_issue;
  import alu_pkg::*;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] rs1, rs2, imm, pc;
    logic [4:0]  rd;
  } ins_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_wb  = 0;
  wb_t  exp_q[$];

  always #5 clk = ~clk;

  alu_issue_if #(.XLEN(32)) bus();
  alu_issue #(.XLEN(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  // external ALU
  function automatic logic [31:0] alu_fn(input logic [3:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0001: r = a << b[4:0];
      4'b0010: r = {31'b0, $signed(a) < $signed(b)};
      4'b0011: r = {31'b0, a < b};
      4'b0100: r = a ^ b;
      4'b0101: r = a >> b[4:0];
      4'b1101: r = $signed(a) >>> b[4:0];
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  assign bus.alu_out_i = alu_fn(bus.alu_op_o, bus.alu_in0_o, bus.alu_in1_o);

  // instruction-level reference: what the register file should receive
  function automatic wb_t ref_model(input ins_t i);
    wb_t         w;
    logic        ill;
    logic [31:0] b, r;
    ill = 1'b0;
    r   = 32'd0;
    b   = (i.opc == OPC_OP) ? i.rs2 : i.imm;
    if (i.opc == OPC_OP || i.opc == OPC_OPIMM) begin
      if (i.opc == OPC_OP && i.f7 && i.f3 != 3'd0 && i.f3 != 3'd5) ill = 1'b1;
      if (i.opc == OPC_OPIMM && i.f7 && i.f3 == 3'd1) ill = 1'b1;
      case (i.f3)
        3'd0: r = (i.opc == OPC_OP && i.f7) ? i.rs1 - b : i.rs1 + b;
        3'd1: r = i.rs1 << b[4:0];
        3'd2: r = ($signed(i.rs1) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (i.rs1 < b) ? 32'd1 : 32'd0;
        3'd4: r = i.rs1 ^ b;
        3'd5: if (i.f7) r = $signed(i.rs1) >>> b[4:0];
              else      r = i.rs1 >> b[4:0];
        3'd6: r = i.rs1 | b;
        default: r = i.rs1 & b;
      endcase
    end else if (i.opc == OPC_LUI) begin
      r = i.imm;
    end else if (i.opc == OPC_AUIPC) begin
      r = i.pc + i.imm;
    end else begin
      ill = 1'b1;
    end
    w.illegal = ill;
    w.we      = !ill && (i.rd != 5'd0);
    w.rd      = i.rd;
    w.data    = ill ? 32'd0 : r;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    ins_t i;
    i.opc = opc; i.f3 = f3; i.f7 = f7; i.rs1 = rs1; i.rs2 = rs2;
    i.imm = imm; i.pc = pc; i.rd = rd;
    return i;
  endfunction

  function automatic ins_t cur_in();
    return mk(bus.opcode_i, bus.funct3_i, bus.funct7b5_i, bus.rs1_data_i,
              bus.rs2_data_i, bus.imm_i, bus.pc_i, bus.rd_i);
  endfunction

  task automatic set_in(input ins_t i);
    bus.opcode_i   = i.opc;
    bus.funct3_i   = i.f3;
    bus.funct7b5_i = i.f7;
    bus.rs1_data_i = i.rs1;
    bus.rs2_data_i = i.rs2;
    bus.imm_i      = i.imm;
    bus.pc_i       = i.pc;
    bus.rd_i       = i.rd;
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // offer one instruction until accepted; returns just after the accept edge
  task automatic send(input ins_t i);
    logic acc;
    acc = 1'b0;
    set_in(i);
    bus.in_valid_i = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready_o;
      tick();
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'(1));
    bus.in_valid_i = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wb_valid"}, 64'(bus.wb_valid_o), 64'(0));
    chk({tag, "_wb_data"},  64'(bus.wb_data_o), 64'(0));
    chk({tag, "_wb_rd_we_ill"}, 64'({bus.wb_rd_o, bus.wb_we_o, bus.wb_illegal_o}), 64'(0));
    chk({tag, "_alu_op"},   64'(bus.alu_op_o), 64'(0));
    chk({tag, "_alu_in0"},  64'(bus.alu_in0_o), 64'(0));
    chk({tag, "_alu_in1"},  64'(bus.alu_in1_o), 64'(0));
  endtask

  function automatic ins_t rand_ins();
    ins_t i;
    logic [31:0] edges [5];
    edges[0] = 32'd0; edges[1] = 32'd1; edges[2] = 32'h7FFF_FFFF;
    edges[3] = 32'h8000_0000; edges[4] = 32'hFFFF_FFFF;
    case ($urandom_range(0, 4))
      0: i.opc = OPC_OP;
      1: i.opc = OPC_OPIMM;
      2: i.opc = OPC_LUI;
      3: i.opc = OPC_AUIPC;
      default: i.opc = 7'($urandom_range(0, 127));
    endcase
    i.f3  = 3'($urandom_range(0, 7));
    i.f7  = 1'($urandom_range(0, 1));
    i.rs1 = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
    i.rs2 = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
    i.imm = $urandom;
    i.pc  = $urandom;
    i.rd  = 5'($urandom_range(0, 31));
    return i;
  endfunction

  // scoreboard: sampled mid-cycle, acts on the transfers of the next edge
  always @(negedge clk) begin
    if (rst || bus.flush_i) begin
      exp_q.delete();
    end else begin
      if (bus.wb_valid_o && bus.wb_ready_i) begin
        n_wb++;
        if (exp_q.size() == 0) chk("wb_spurious", 64'(1), 64'(0));
        else chk("wb_pkt", 64'({bus.wb_illegal_o, bus.wb_we_o, bus.wb_rd_o, bus.wb_data_o}),
                 64'(exp_q.pop_front()));
      end
      if (bus.in_valid_i && bus.in_ready_o) exp_q.push_back(ref_model(cur_in()));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    ins_t s [4];
    int   idx, cyc, base;
    logic stall, prev_stall, prev_rdy, saw_low, acc;
    logic [63:0] prev_wb, prev_alu;

    rst = 1'b1;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.wb_ready_i = 1'b1;
    set_in(mk(OPC_OP, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0));
    tick(2);
    check_zero("reset");
    rst = 1'b0;
    tick();

    // ADD, latency
    send(mk(OPC_OP, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3));
    chk("add_alu_op", 64'(bus.alu_op_o), 64'(4'b0000));
    chk("add_alu_in0", 64'(bus.alu_in0_o), 64'(5));
    chk("add_alu_in1", 64'(bus.alu_in1_o), 64'(7));
    tick();
    chk("add_wb_valid", 64'(bus.wb_valid_o), 64'(1));
    chk("add_wb", 64'({bus.wb_we_o, bus.wb_rd_o, bus.wb_data_o}), 64'({1'b1, 5'd3, 32'd12}));

    send(mk(OPC_OP, 3'd0, 1'b1, 32'd0, 32'd1, 32'd0, 32'd0, 5'd4));
    chk("sub_alu_op", 64'(bus.alu_op_o), 64'(4'b1000));
    tick();
    chk("sub_wb_data", 64'(bus.wb_data_o), 64'(32'hFFFF_FFFF));

    send(mk(OPC_OPIMM, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'h401, 32'd0, 5'd6));
    chk("srai_alu_in1", 64'(bus.alu_in1_o), 64'(1));
    chk("srai_alu_op", 64'(bus.alu_op_o), 64'(4'b1101));
    tick();
    chk("srai_wb_data", 64'(bus.wb_data_o), 64'(32'hC000_0000));

    send(mk(OPC_OP, 3'd1, 1'b0, 32'd3, 32'h21, 32'd0, 32'd0, 5'd7));
    chk("sll_alu_in1", 64'(bus.alu_in1_o), 64'(1));
    chk("sll_alu_op", 64'(bus.alu_op_o), 64'(4'b0001));
    tick();
    chk("sll_wb_data", 64'(bus.wb_data_o), 64'(6));

    send(mk(OPC_LUI, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'h1234_5000, 32'd0, 5'd8));
    tick();
    chk("lui_wb_data", 64'(bus.wb_data_o), 64'(32'h1234_5000));

    send(mk(OPC_AUIPC, 3'd0, 1'b0, 32'd9, 32'd0, 32'h1000, 32'h100, 5'd9));
    tick();
    chk("auipc_wb_data", 64'(bus.wb_data_o), 64'(32'h1100));

    send(mk(7'h7F, 3'd0, 1'b0, 32'd11, 32'd12, 32'd13, 32'd14, 5'd5));
    tick();
    chk("illegal_wb", 64'({bus.wb_illegal_o, bus.wb_we_o, bus.wb_rd_o, bus.wb_data_o}),
        64'({1'b1, 1'b0, 5'd5, 32'd0}));

    send(mk(OPC_OP, 3'd6, 1'b0, 32'hF0, 32'h0F, 32'd0, 32'd0, 5'd0));
    tick();
    chk("rd0_wb", 64'({bus.wb_illegal_o, bus.wb_we_o, bus.wb_rd_o, bus.wb_data_o}),
        64'({1'b0, 1'b0, 5'd0, 32'hFF}));
    tick(3);

    // back-to-back stream with a 3-cycle writeback stall
    for (int k = 0; k < 4; k++)
      s[k] = mk(OPC_OP, 3'd0, 1'b0, 32'(100 * (k + 1)), 32'(k + 1), 32'd0, 32'd0, 5'(k + 10));
    idx = 0; cyc = 0; base = n_wb;
    prev_stall = 1'b0; prev_rdy = 1'b1; saw_low = 1'b0;
    prev_wb = '0; prev_alu = '0;
    while ((idx < 4 || cyc < 8) && cyc < 30) begin
      if (idx < 4) begin set_in(s[idx]); bus.in_valid_i = 1'b1; end
      else bus.in_valid_i = 1'b0;
      bus.wb_ready_i = !(cyc >= 2 && cyc <= 4);
      @(negedge clk);
      stall = bus.wb_valid_o && !bus.wb_ready_i;
      if (stall && !bus.in_ready_o) saw_low = 1'b1;
      if (stall && prev_stall) begin
        chk("stall_wb_hold", 64'({bus.wb_valid_o, bus.wb_illegal_o, bus.wb_we_o,
                                  bus.wb_rd_o, bus.wb_data_o}), prev_wb);
        if (!prev_rdy)
          chk("stall_alu_hold", 64'({bus.alu_op_o, bus.alu_in0_o[27:0], bus.alu_in1_o}), prev_alu);
      end
      prev_stall = stall;
      prev_rdy   = bus.in_ready_o;
      prev_wb    = 64'({bus.wb_valid_o, bus.wb_illegal_o, bus.wb_we_o, bus.wb_rd_o, bus.wb_data_o});
      prev_alu   = 64'({bus.alu_op_o, bus.alu_in0_o[27:0], bus.alu_in1_o});
      acc = bus.in_valid_i && bus.in_ready_o;
      tick();
      if (acc) idx++;
      cyc++;
    end
    bus.in_valid_i = 1'b0; bus.wb_ready_i = 1'b1;
    tick(3);
    chk("stall_ready_low", 64'(saw_low), 64'(1));
    chk("stall_wb_count", 64'(n_wb - base), 64'(4));

    // flush with both stages full and a new offer
    bus.wb_ready_i = 1'b0;
    send(mk(OPC_OP, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd1));
    send(mk(OPC_OP, 3'd4, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, 5'd2));
    set_in(mk(OPC_OP, 3'd0, 1'b0, 32'd7, 32'd7, 32'd0, 32'd0, 5'd3));
    bus.in_valid_i = 1'b1; bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(bus.in_ready_o), 64'(0));
    tick();
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    chk("flush_wb_valid", 64'(bus.wb_valid_o), 64'(0));
    bus.wb_ready_i = 1'b1;
    tick(3);
    chk("flush_nothing_taken", 64'(bus.wb_valid_o), 64'(0));

    // reset with both stages full
    bus.wb_ready_i = 1'b0;
    send(mk(OPC_OP, 3'd6, 1'b0, 32'hAA, 32'h55, 32'd0, 32'd0, 5'd4));
    send(mk(OPC_OP, 3'd0, 1'b0, 32'd9, 32'd9, 32'd0, 32'd0, 5'd5));
    rst = 1'b1;
    tick();
    check_zero("midreset");
    rst = 1'b0; bus.wb_ready_i = 1'b1;
    tick(3);
    chk("midreset_no_wb", 64'(bus.wb_valid_o), 64'(0));

    // randomized traffic, scoreboard does the checking
    for (int c = 0; c < 400; c++) begin
      set_in(rand_ins());
      bus.in_valid_i = ($urandom_range(0, 3) != 0);
      bus.wb_ready_i = ($urandom_range(0, 3) != 0);
      bus.flush_i    = ($urandom_range(0, 24) == 0);
      tick();
    end
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.wb_ready_i = 1'b1;
    tick(5);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
